madd_msub_ctrl: RTL and testbench
=================================

# madd_msub_ctrl

Sequencing controller for the 256-bit modular add/subtract datapath (`MADD_MSUB_DATAPATH`). It loads the modulus P and the operands A and B word-serially through a valid/ready handshake, and drives the datapath's write-enable, rotate, mux and carry controls through two fixed 16-cycle arithmetic passes. It then picks the reduced result from the datapath's sign flags and streams it out word-serially. It sits directly upstream of the datapath and owns every datapath control input.

## Interface
Parameters:
- `WORDS`, 16: words per 256-bit operand; fixed, counter is 4 bits.

Ports (clock and reset first):
- `clk`  in  1  single clock; all state on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  command strobe; honoured only in IDLE.
- `op`  in  2  sampled with `start`: 00 = mod add, 01 = mod sub, 10 = load P, 11 = reserved (ignored, stays IDLE).
- `in_valid`  in  1  input word valid (data travels on datapath `datain`).
- `in_ready`  out  1  controller accepts an input word this cycle.
- `out_valid`  out  1  result word on the selected datapath output.
- `out_ready`  in  1  consumer takes the word.
- `out_sel`  out  1  0 = result in regs0out, 1 = result in regs1out; stable from end of PASS2 until `done`.
- `busy`  out  1  high whenever state is not IDLE.
- `done`  out  1  one-cycle pulse after the last output word (or last P word) is accepted.
- `sign_a_b`, `sign_a_b_p`  in  1  datapath flags.
- `rega_we`, `regb_we`, `regp_we`, `regs0_we`, `regs1_we`, `dff1_we`  out  1  datapath enables.
- `rega_cyc`, `regb_cyc`, `regp_cyc`, `regs0_cyc`, `regs1_cyc`  out  1  datapath rotate controls.
- `carry_sel`, `mux0_sel`, `mux1_sel`, `add_sub`  out  1  datapath steering.

## Operation
Datapath contract:
- `_we` shifts `datain` or `sum_16` in, and has priority over `_cyc`.
- `_cyc` rotates the register by one word.
- The current output word is the least significant one; operands load LSW first.
- `mux0_sel` 0 = A, 1 = S0. `mux1_sel` 0 = B, 1 = P.
- `carry_sel` 0 = carry-in from `add_sub`, 1 = registered carry.

States:
- IDLE: all outputs 0.
  - `start` with op 10 goes to LOAD_P.
  - `start` with op 00 or 01 latches op and goes to LOAD_A.
- LOAD_P, LOAD_A, LOAD_B: `in_ready` = 1.
  - Each `in_valid & in_ready` asserts the matching `reg*_we` for that cycle and increments the word counter.
  - At word 15, LOAD_P pulses `done` and returns to IDLE; LOAD_A goes to LOAD_B; LOAD_B goes to PASS1.
  - No enable is asserted without a handshake.
- PASS1 (16 cycles, no stalls): S0 = A ± B into regs0.
  - `regs0_we` = 1, `rega_cyc` = `regb_cyc` = 1, `mux0_sel` = 0, `mux1_sel` = 0.
  - `add_sub` = op (0 add, 1 sub). `carry_sel` = 0 on word 0, 1 otherwise.
  - Word 15: `dff1_we` = 1. For sub, latch `neg = sign_a_b`.
- PASS2 (16 cycles): S1 = S0 ∓ P into regs1.
  - `regs1_we` = 1, `regs0_cyc` = `regp_cyc` = 1, `mux0_sel` = 1, `mux1_sel` = 1.
  - `add_sub` = ~op. `carry_sel` as in PASS1.
  - Word 15 selects the result: add gives `out_sel = ~sign_a_b_p` (a+b<p keeps S0); sub gives `out_sel = neg`.
  - PASS2 always runs, so compute latency is constant.
- OUT: `out_valid` = 1.
  - On each handshake, assert `regs0_cyc` (`out_sel` = 0) or `regs1_cyc` (`out_sel` = 1); the other register is untouched.
  - After word 15 is accepted, pulse `done` and go to IDLE. A and B and P return to their original alignment.

Rules:
- `start` outside IDLE is ignored. `op` is latched only at `start`.
- P persists across operations until reloaded. A/B/S0/S1 are overwritten by each operation.
- Inputs are assumed to satisfy A, B < P; results are unspecified otherwise.

## Timing
- Reset: state IDLE, counter 0, `out_sel` 0, `neg` 0, every output 0.
- Reset mid-operation aborts to IDLE the next cycle. `in_ready`/`out_valid` go low; register contents are undefined except P if LOAD_P was not in progress.
- LOAD_B word-15 handshake to first PASS1 cycle: 1 cycle. PASS1 + PASS2 = 32 cycles. First `out_valid` appears the cycle after PASS2 word 15.
- Minimum op latency (no stalls): 32 load + 32 compute + 16 out cycles; `done` in the cycle after the last accepted word.
- Flags are sampled combinationally at word 15 of each pass. `carry256` from PASS1 word 15 is valid throughout PASS2.
- `done` and `start` in the same cycle: `start` is ignored, because the state is not yet IDLE.

## Test plan
- P = 13, add A = 7, B = 9: S0 = 16, `sign_a_b_p` = 0, so `out_sel` = 1, result 3, `done` after 80 cycles with no stalls.
- P = 13, add A = 3, B = 4: `out_sel` = 0, result 7. Sub A = 9, B = 4: `out_sel` = 0, result 5.
- P = 13, sub A = 3, B = 5: `sign_a_b` = 1, `out_sel` = 1, result 11.
- P = 2^256−189, add A = B = P−1: 256-bit overflow sets `carry256`, `out_sel` = 1, result P−2. Every carry chain across all 16 words is exercised.
- Random `in_valid`/`out_ready` throttling (about 50% duty): results identical to the unstalled runs, no enable asserted without a handshake, a second `start` during OUT is ignored.
- `rst` asserted at PASS1 word 7: next cycle IDLE, all outputs 0. A fresh add with P retained then completes correctly.

Source files
------------

// File: rtl/madd_msub_ctrl.sv
// madd_msub_ctrl: word-serial load, two fixed 16-cycle add/sub passes and result
// streaming for the 256-bit modular add/subtract datapath.
module madd_msub_ctrl #(
    parameter int WORDS = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [1:0] op,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_sel,
    output logic       busy,
    output logic       done,
    input  logic       sign_a_b,
    input  logic       sign_a_b_p,
    output logic       rega_we,
    output logic       regb_we,
    output logic       regp_we,
    output logic       regs0_we,
    output logic       regs1_we,
    output logic       dff1_we,
    output logic       rega_cyc,
    output logic       regb_cyc,
    output logic       regp_cyc,
    output logic       regs0_cyc,
    output logic       regs1_cyc,
    output logic       carry_sel,
    output logic       mux0_sel,
    output logic       mux1_sel,
    output logic       add_sub
);
    typedef enum logic [2:0] {IDLE, LOAD_P, LOAD_A, LOAD_B, PASS1, PASS2, OUT, DONE} state_t;
    state_t     state, state_n;
    logic [3:0] cnt;
    logic       sub, neg, sel, last, step;
    assign last    = cnt == 4'(WORDS - 1);
    assign out_sel = sel;
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            sub   <= 1'b0;
            neg   <= 1'b0;
            sel   <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= step ? cnt + 4'd1 : cnt;
            if (state == IDLE && start && !op[1]) sub <= op[0];
            if (state == PASS1 && last && sub) neg <= sign_a_b;
            // a+b < p keeps S0; a-b < 0 takes S1 = S0 + P
            if (state == PASS2 && last) sel <= sub ? neg : ~sign_a_b_p;
            else if (state == DONE) sel <= 1'b0;
        end
    end
    always_comb begin
        state_n   = state;
        busy      = state != IDLE;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        done      = 1'b0;
        rega_we   = 1'b0;
        regb_we   = 1'b0;
        regp_we   = 1'b0;
        regs0_we  = 1'b0;
        regs1_we  = 1'b0;
        dff1_we   = 1'b0;
        rega_cyc  = 1'b0;
        regb_cyc  = 1'b0;
        regp_cyc  = 1'b0;
        regs0_cyc = 1'b0;
        regs1_cyc = 1'b0;
        carry_sel = 1'b0;
        mux0_sel  = 1'b0;
        mux1_sel  = 1'b0;
        add_sub   = 1'b0;
        case (state)
            IDLE:   state_n = !start ? IDLE : op == 2'b10 ? LOAD_P : op[1] ? IDLE : LOAD_A;
            LOAD_P: begin
                in_ready = 1'b1;
                regp_we  = in_valid;
                state_n  = in_valid && last ? DONE : LOAD_P;
            end
            LOAD_A: begin
                in_ready = 1'b1;
                rega_we  = in_valid;
                state_n  = in_valid && last ? LOAD_B : LOAD_A;
            end
            LOAD_B: begin
                in_ready = 1'b1;
                regb_we  = in_valid;
                state_n  = in_valid && last ? PASS1 : LOAD_B;
            end
            PASS1: begin
                regs0_we  = 1'b1;
                rega_cyc  = 1'b1;
                regb_cyc  = 1'b1;
                add_sub   = sub;
                carry_sel = cnt != 4'd0;
                dff1_we   = last;
                state_n   = last ? PASS2 : PASS1;
            end
            PASS2: begin
                regs1_we  = 1'b1;
                regs0_cyc = 1'b1;
                regp_cyc  = 1'b1;
                mux0_sel  = 1'b1;
                mux1_sel  = 1'b1;
                add_sub   = ~sub;
                carry_sel = cnt != 4'd0;
                state_n   = last ? OUT : PASS2;
            end
            OUT: begin
                out_valid = 1'b1;
                regs0_cyc = out_ready & ~sel;
                regs1_cyc = out_ready & sel;
                state_n   = out_ready && last ? DONE : OUT;
            end
            DONE: begin
                done    = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
        step = (in_ready & in_valid) | (out_valid & out_ready) | (state == PASS1) | (state == PASS2);
    end
endmodule

// File: tb/tb_madd_msub_ctrl.sv
// tb_madd_msub_ctrl: drives the controller against a word-level datapath model and
// checks streamed results against modular arithmetic on whole 256-bit values.
module tb_madd_msub_ctrl;
    logic clk = 0, rst = 1, start = 0, in_valid = 0, out_ready = 0;
    logic [1:0] op = 0;
    logic in_ready, out_valid, out_sel, busy, done, sign_a_b, sign_a_b_p;
    logic rega_we, regb_we, regp_we, regs0_we, regs1_we, dff1_we;
    logic rega_cyc, regb_cyc, regp_cyc, regs0_cyc, regs1_cyc;
    logic carry_sel, mux0_sel, mux1_sel, add_sub;

    always #5 clk = ~clk;

    madd_msub_ctrl #(.WORDS(16)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op),
        .in_valid(in_valid), .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
        .out_sel(out_sel), .busy(busy), .done(done),
        .sign_a_b(sign_a_b), .sign_a_b_p(sign_a_b_p),
        .rega_we(rega_we), .regb_we(regb_we), .regp_we(regp_we),
        .regs0_we(regs0_we), .regs1_we(regs1_we), .dff1_we(dff1_we),
        .rega_cyc(rega_cyc), .regb_cyc(regb_cyc), .regp_cyc(regp_cyc),
        .regs0_cyc(regs0_cyc), .regs1_cyc(regs1_cyc),
        .carry_sel(carry_sel), .mux0_sel(mux0_sel), .mux1_sel(mux1_sel), .add_sub(add_sub)
    );

    // Datapath model: 256-bit shift/rotate registers, one 16-bit adder slice
    logic [255:0] ra = '0, rb = '0, rp = '0, s0 = '0, s1 = '0;
    logic cr = 0, c256 = 0;
    logic [15:0] datain = '0;
    logic [16:0] sum;
    always_comb begin
        sum = {1'b0, mux0_sel ? s0[15:0] : ra[15:0]}
            + {1'b0, (mux1_sel ? rp[15:0] : rb[15:0]) ^ {16{add_sub}}}
            + {16'd0, carry_sel ? cr : add_sub};
        sign_a_b   = ~sum[16];
        sign_a_b_p = ~sum[16] & ~c256;
    end
    always @(posedge clk) begin
        cr <= sum[16];
        if (dff1_we) c256 <= sum[16];
        ra <= rega_we ? {datain, ra[255:16]} : rega_cyc ? {ra[15:0], ra[255:16]} : ra;
        rb <= regb_we ? {datain, rb[255:16]} : regb_cyc ? {rb[15:0], rb[255:16]} : rb;
        rp <= regp_we ? {datain, rp[255:16]} : regp_cyc ? {rp[15:0], rp[255:16]} : rp;
        s0 <= regs0_we ? {sum[15:0], s0[255:16]} : regs0_cyc ? {s0[15:0], s0[255:16]} : s0;
        s1 <= regs1_we ? {sum[15:0], s1[255:16]} : regs1_cyc ? {s1[15:0], s1[255:16]} : s1;
    end

    int checks = 0, errors = 0, cyc = 0, nres = 0, done_cyc = 0;
    bit done_seen = 0;
    logic sel_at_done = 0;
    logic [255:0] res = '0, cur_p = '0;

    task automatic chk(input string name, input logic [256:0] act, input logic [256:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) if (!rst) begin
        chk("we_without_handshake", (rega_we | regb_we | regp_we) & ~(in_valid & in_ready), 0);
        if (out_valid) begin
            chk("out_rotate", {regs0_cyc, regs1_cyc}, {out_ready & ~out_sel, out_ready & out_sel});
            if (out_ready) begin
                res = {out_sel ? s1[15:0] : s0[15:0], res[255:16]};
                nres++;
            end
        end
        if (done) begin
            done_seen   = 1;
            done_cyc    = cyc;
            sel_at_done = out_sel;
        end
    end

    // Returns {select-S1, reduced result}
    function automatic logic [256:0] model(input logic sub, input logic [255:0] p, a, b);
        logic [256:0] t;
        if (!sub) begin
            t = {1'b0, a} + {1'b0, b};
            return t >= {1'b0, p} ? {1'b1, t[255:0] - p} : {1'b0, t[255:0]};
        end
        return a < b ? {1'b1, a - b + p} : {1'b0, a - b};
    endfunction

    function automatic logic [255:0] rnd256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic issue(input logic [1:0] o, output int t0);
        start = 1;
        op    = o;
        t0    = cyc;
        @(posedge clk); #1;
        start = 0;
    endtask

    task automatic send(input logic [255:0] v, input int duty);
        int i = 0, g = 0;
        bit hs;
        while (i < 16 && g < 2000) begin
            in_valid = duty >= 100 || $urandom_range(0, 99) < duty;
            datain   = v[i*16 +: 16];
            @(negedge clk);
            hs = in_valid && in_ready;
            @(posedge clk); #1;
            g++;
            if (hs) i++;
        end
        in_valid = 0;
        chk("send_words", i, 16);
    endtask

    task automatic load_p(input logic [255:0] p, input int duty);
        int t0, g = 0;
        done_seen = 0;
        issue(2'b10, t0);
        send(p, duty);
        while (!done_seen && g < 20) begin @(posedge clk); #1; g++; end
        chk("p_done", done_seen, 1);
        if (duty >= 100) chk("p_latency", done_cyc - t0, 17);
        cur_p = p;
    endtask

    task automatic run_op(input logic sub, input logic [255:0] a, b, input int duty, input bit poke);
        int t0, g = 0;
        bit poked = 0;
        logic [256:0] e;
        e = model(sub, cur_p, a, b);
        nres = 0;
        res = '0;
        done_seen = 0;
        out_ready = duty >= 100;
        issue({1'b0, sub}, t0);
        send(a, duty);
        send(b, duty);
        while (!done_seen && g < 3000) begin
            out_ready = duty >= 100 || $urandom_range(0, 99) < duty;
            start = poke && out_valid && !poked;
            if (start) poked = 1;
            @(posedge clk); #1;
            g++;
        end
        start = 0;
        out_ready = 0;
        chk("op_done", done_seen, 1);
        chk("word_count", nres, 16);
        chk("result", res, e[255:0]);
        chk("out_sel", sel_at_done, e[256]);
        if (duty >= 100) chk("latency", done_cyc - t0, 81);
        @(negedge clk);
        chk("idle_after_done", busy, 0);
        @(posedge clk); #1;
    endtask

    task automatic chk_idle(input string n);
        @(negedge clk);
        chk(n, {in_ready, out_valid, out_sel, busy, done, rega_we, regb_we, regp_we, regs0_we,
                regs1_we, dff1_we, rega_cyc, regb_cyc, regp_cyc, regs0_cyc, regs1_cyc,
                carry_sel, mux0_sel, mux1_sel, add_sub}, 0);
    endtask

    initial begin
        logic [255:0] pb, pr, a, b;
        int t0;
        chk("pin_add_wrap", model(0, 13, 7, 9), {1'b1, 256'd3});
        chk("pin_sub_neg", model(1, 13, 3, 5), {1'b1, 256'd11});
        repeat (3) @(posedge clk);
        #1 rst = 0;
        chk_idle("reset_idle");
        @(posedge clk); #1;
        issue(2'b11, t0);
        @(negedge clk);
        chk("reserved_op_idle", busy, 0);
        @(posedge clk); #1;
        load_p(13, 100);
        run_op(0, 7, 9, 100, 0);
        chk("lit_add_7_9", {sel_at_done, res}, {1'b1, 256'd3});
        run_op(0, 3, 4, 100, 0);
        chk("lit_add_3_4", {sel_at_done, res}, {1'b0, 256'd7});
        run_op(1, 9, 4, 100, 0);
        chk("lit_sub_9_4", {sel_at_done, res}, {1'b0, 256'd5});
        run_op(1, 3, 5, 100, 0);
        chk("lit_sub_3_5", {sel_at_done, res}, {1'b1, 256'd11});
        // Reset during PASS1 word 7, then a fresh add with P retained
        issue(2'b00, t0);
        send(7, 100);
        send(9, 100);
        repeat (7) begin @(posedge clk); #1; end
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        chk_idle("reset_mid_pass1");
        @(posedge clk); #1;
        run_op(0, 7, 9, 100, 0);
        chk("lit_after_reset", res, 256'd3);
        for (int i = 0; i < 4; i++) run_op(1'($urandom), $urandom_range(0, 12), $urandom_range(0, 12), 50, 1);
        pb = '1;
        pb = pb - 188;
        load_p(pb, 100);
        run_op(0, pb - 1, pb - 1, 100, 0);
        chk("lit_big_overflow", {sel_at_done, res}, {1'b1, pb - 256'd2});
        pr = rnd256() | {1'b1, 255'd0};
        load_p(pr, 50);
        for (int i = 0; i < 6; i++) begin
            a = rnd256();
            b = rnd256();
            if (a >= pr) a = a - pr;
            if (b >= pr) b = b - pr;
            run_op(1'($urandom), a, b, 50, 1);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
